network_sync_ctrl: RTL and testbench
====================================

// Module: network_sync_ctrl
// PURPOSE
// Network-level controller downstream of the per-actor triggers. It gathers each trigger's
// sync-wait and executed indications and issues round-boundary all_sync pulses back to them.
// It finishes the network (ap_done) after a full round in which no actor executed.
// It presents the HLS-style ap_start/ap_done/ap_idle/ap_ready handshake to the host-side wrapper.
// PARAMETERS
// NUM_ACTORS     4    number of attached triggers (>=1)
// SETTLE_CYCLES  2    cycles after an all_sync pulse before sync_wait is sampled again (>=1)
// CNT_W          32   width of exec_count
// ROUND_W        16   width of round_count
// PORTS
// ap_clk         in   1           clock
// ap_rst         in   1           synchronous active-high reset
// ap_start       in   1           start network; sampled only in IDLE
// ap_done        out  1           one-cycle pulse: network quiescent
// ap_idle        out  1           high while in IDLE
// ap_ready       out  1           equals ap_done
// sync_wait      in   NUM_ACTORS  trigger i parked at a sync point (level)
// exec_pulse     in   NUM_ACTORS  trigger i saw an EXECUTED return (one cycle per firing)
// all_sync       out  1           one-cycle broadcast: every trigger relaunches once
// all_waiting    out  1           combinational &sync_wait
// exec_count     out  CNT_W       total EXECUTED firings since start, saturating
// round_count    out  ROUND_W     sync rounds issued since start, saturating
// BEHAVIOUR
// Reset (any state, mid-run included): state=IDLE; ap_idle=1; ap_done=ap_ready=all_sync=0;
//   counters=0; exec_mask=0; settle=0. all_waiting follows its inputs even during reset.
// States: IDLE, RUN, SYNC, SETTLE, CHECK, DONE. All outputs except all_waiting are registered.
// IDLE: ap_idle=1. If ap_start: clear exec_count, round_count and exec_mask, then go to RUN.
// RUN: exec_mask |= exec_pulse. When &sync_wait, go to SYNC.
// SYNC: all_sync=1 for exactly this cycle; exec_mask<=0; round_count+=1 (saturating);
//   settle<=SETTLE_CYCLES-1; next state SETTLE.
// SETTLE: count settle down to 0, then go to CHECK. sync_wait is ignored here.
// CHECK: exec_mask |= exec_pulse. When &sync_wait:
//   - mask including this cycle's exec_pulse == 0: go to DONE;
//   - otherwise go to SYNC.
//   If not all waiting, stay in CHECK.
// DONE: ap_done=ap_ready=1 for one cycle, then go to IDLE.
// exec_count: adds popcount(exec_pulse) every cycle outside IDLE and DONE, saturating at 2^CNT_W-1.
//   Simultaneous pulses from several actors in one cycle are all counted.
// exec_pulse arriving in the same cycle as the &sync_wait sample is counted and masked.
// ap_start while not in IDLE is ignored; ap_start held high in DONE starts a new run one cycle
//   after the return to IDLE.
// Minimum latency, all actors already waiting and none executing: ap_start (IDLE) -> RUN -> SYNC
//   -> SETTLE x SETTLE_CYCLES -> CHECK -> DONE. ap_done is high SETTLE_CYCLES+3 cycles after
//   the ap_start sampling edge.
// NUM_ACTORS=1 is legal; every reduction degenerates to the single bit.
// TESTING
// Reset mid-SETTLE with counters nonzero -> next cycle IDLE, ap_idle=1, counters=0, all_sync=0.
// N=4, sync_wait=4'hF held, no exec; start -> exactly 1 all_sync, ap_done at cycle SETTLE+3,
//   round_count=1.
// N=4; exec_pulse=4'b0101 in round 1, 4'b0010 in round 2, none in round 3 -> 3 all_sync pulses,
//   exec_count=3, round_count=3, then ap_done.
// exec_pulse=4'b1000 coincident with the &sync_wait sample in CHECK -> another SYNC, not DONE.
// Counter saturation (CNT_W=4): 20 single pulses -> exec_count stays at 15; round_count saturates likewise.
// ap_start pulses during RUN/CHECK ignored; ap_start held through DONE -> restart, counters cleared.

Source files
------------

// File: rtl/network_sync_ctrl.sv
// Network-level sync controller: gathers trigger sync/exec status,
// issues round-boundary all_sync pulses and an HLS ap_* handshake.
module network_sync_ctrl #(
   parameter int NUM_ACTORS    = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 32,
   parameter int ROUND_W       = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ap_start,
   output logic                  ap_done,
   output logic                  ap_idle,
   output logic                  ap_ready,
   input  logic [NUM_ACTORS-1:0] sync_wait,
   input  logic [NUM_ACTORS-1:0] exec_pulse,
   output logic                  all_sync,
   output logic                  all_waiting,
   output logic [CNT_W-1:0]      exec_count,
   output logic [ROUND_W-1:0]    round_count
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int POP_W = $clog2(NUM_ACTORS + 1);

   typedef enum logic [2:0] {
      IDLE, RUN, SYNC, SETTLE, CHECK, DONE
   } state_t;

   state_t                state, state_nx;
   logic [NUM_ACTORS-1:0] exec_mask, mask_nx, mask_all;
   logic [SET_W-1:0]      settle, settle_nx;
   logic [POP_W-1:0]      pop;
   logic [CNT_W:0]        exec_sum;
   logic [CNT_W-1:0]      exec_sat;
   logic                  count_en, clr, round_inc;

   assign all_waiting = &sync_wait;
   assign ap_ready    = ap_done;
   assign mask_all    = exec_mask | exec_pulse;

   // Number of actors firing this cycle, and the saturated running total
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_ACTORS; i++)
         pop = pop + POP_W'(exec_pulse[i]);
      exec_sum = {1'b0, exec_count} + (CNT_W + 1)'(pop);
      exec_sat = exec_sum[CNT_W] ? '1 : exec_sum[CNT_W-1:0];
   end

   // Next-state and per-state datapath controls
   always_comb begin
      state_nx  = state;
      mask_nx   = exec_mask;
      settle_nx = settle;
      clr       = 1'b0;
      round_inc = 1'b0;
      count_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (ap_start) begin
               clr      = 1'b1;
               mask_nx  = '0;
               state_nx = RUN;
            end
         end
         RUN: begin
            count_en = 1'b1;
            mask_nx  = mask_all;
            if (all_waiting)
               state_nx = SYNC;
         end
         SYNC: begin
            count_en  = 1'b1;
            mask_nx   = '0;
            round_inc = 1'b1;
            settle_nx = SET_W'(SETTLE_CYCLES - 1);
            state_nx  = SETTLE;
         end
         SETTLE: begin
            count_en = 1'b1;
            if (settle == '0)
               state_nx = CHECK;
            else
               settle_nx = settle - SET_W'(1);
         end
         CHECK: begin
            count_en = 1'b1;
            mask_nx  = mask_all;
            if (all_waiting)
               state_nx = (|mask_all) ? SYNC : DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, counters and registered handshake outputs
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state       <= IDLE;
         exec_mask   <= '0;
         settle      <= '0;
         exec_count  <= '0;
         round_count <= '0;
         ap_idle     <= 1'b1;
         ap_done     <= 1'b0;
         all_sync    <= 1'b0;
      end else begin
         state     <= state_nx;
         exec_mask <= mask_nx;
         settle    <= settle_nx;
         ap_idle   <= (state_nx == IDLE);
         ap_done   <= (state_nx == DONE);
         all_sync  <= (state_nx == SYNC);
         if (clr)
            exec_count <= '0;
         else if (count_en)
            exec_count <= exec_sat;
         if (clr)
            round_count <= '0;
         else if (round_inc && (round_count != '1))
            round_count <= round_count + ROUND_W'(1);
      end
   end

endmodule

// File: tb/tb_network_sync_ctrl.sv
// Bench for network_sync_ctrl: cycle vector table with a scoreboard
// queue, plus a hand sequence on a narrow-counter instance.
module tb_network_sync_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, done, idle, ready, sync, aw;
   logic [3:0]  sw, ep;
   logic [31:0] exec;
   logic [15:0] round;

   logic        s_rst, s_start, s_done, s_idle, s_ready, s_sync, s_aw;
   logic [3:0]  s_sw, s_ep;
   logic [3:0]  s_exec;
   logic [2:0]  s_round;

   int checks = 0;
   int errors = 0;

   network_sync_ctrl #(
      .NUM_ACTORS(4), .SETTLE_CYCLES(2), .CNT_W(32), .ROUND_W(16)
   ) dut (
      .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(done),
      .ap_idle(idle), .ap_ready(ready), .sync_wait(sw), .exec_pulse(ep),
      .all_sync(sync), .all_waiting(aw), .exec_count(exec),
      .round_count(round)
   );

   network_sync_ctrl #(
      .NUM_ACTORS(4), .SETTLE_CYCLES(2), .CNT_W(4), .ROUND_W(3)
   ) dut_sat (
      .ap_clk(clk), .ap_rst(s_rst), .ap_start(s_start), .ap_done(s_done),
      .ap_idle(s_idle), .ap_ready(s_ready), .sync_wait(s_sw),
      .exec_pulse(s_ep), .all_sync(s_sync), .all_waiting(s_aw),
      .exec_count(s_exec), .round_count(s_round)
   );

   typedef struct {
      logic        rst;
      logic        start;
      logic [3:0]  sw;
      logic [3:0]  ep;
      logic        idle;
      logic        done;
      logic        sync;
      logic [31:0] exec;
      logic [15:0] round;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   task automatic v(input logic r, input logic st, input logic [3:0] w,
                    input logic [3:0] e, input logic i, input logic d,
                    input logic s, input int x, input int rc);
      vec_t t;
      t.rst = r; t.start = st; t.sw = w; t.ep = e;
      t.idle = i; t.done = d; t.sync = s;
      t.exec = x; t.round = 16'(rc);
      vecs.push_back(t);
   endtask

   task automatic check(input string nm, input int idx,
                        input longint act, input longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s vec %0d got %0h want %0h", nm, idx, act, want);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      rst = 1'b1; start = 1'b0; sw = '0; ep = '0;
      s_rst = 1'b1; s_start = 1'b0; s_sw = '0; s_ep = '0;

      //  rst st sw     ep     idl dn sy exec rnd
      // reset state, all_waiting live during reset
      v(1, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      v(1, 1, 4'hF, 4'h0, 1, 0, 0, 0, 0);
      v(0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      // minimum latency: done SETTLE+3 edges after start
      v(0, 1, 4'hF, 4'h0, 0, 0, 0, 0, 0);
      v(0, 0, 4'hF, 4'h0, 0, 0, 1, 0, 0);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 1);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 1);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 1);
      v(0, 0, 4'hF, 4'h0, 0, 1, 0, 0, 1);
      v(0, 0, 4'hF, 4'h0, 1, 0, 0, 0, 1);
      // three rounds: 0101, then 0010 coincident with the sample
      v(0, 1, 4'hF, 4'h0, 0, 0, 0, 0, 0);
      v(0, 0, 4'hF, 4'h0, 0, 0, 1, 0, 0);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 1);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 1);
      v(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 1);
      v(0, 1, 4'h0, 4'h5, 0, 0, 0, 2, 1);
      v(0, 0, 4'hF, 4'h0, 0, 0, 1, 2, 1);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 2, 2);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 2, 2);
      v(0, 0, 4'h0, 4'h0, 0, 0, 0, 2, 2);
      v(0, 0, 4'hF, 4'h2, 0, 0, 1, 3, 2);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 3, 3);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 3, 3);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 3, 3);
      v(0, 0, 4'hF, 4'h0, 0, 1, 0, 3, 3);
      v(0, 0, 4'hF, 4'h0, 1, 0, 0, 3, 3);
      // start ignored in RUN, 1000 coincident in CHECK, start held in DONE
      v(0, 1, 4'h0, 4'h0, 0, 0, 0, 0, 0);
      v(0, 1, 4'h0, 4'h8, 0, 0, 0, 1, 0);
      v(0, 0, 4'hF, 4'h0, 0, 0, 1, 1, 0);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 1, 1);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 1, 1);
      v(0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1);
      v(0, 0, 4'hF, 4'h8, 0, 0, 1, 2, 1);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 2, 2);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 2, 2);
      v(0, 0, 4'hF, 4'h0, 0, 0, 0, 2, 2);
      v(0, 1, 4'hF, 4'h0, 0, 1, 0, 2, 2);
      v(0, 1, 4'hF, 4'h0, 1, 0, 0, 2, 2);
      v(0, 1, 4'hF, 4'h0, 0, 0, 0, 0, 0);
      // simultaneous pulses in SYNC, then reset mid-SETTLE
      v(0, 0, 4'hF, 4'h0, 0, 0, 1, 0, 0);
      v(0, 0, 4'hF, 4'hF, 0, 0, 0, 4, 1);
      v(1, 0, 4'hF, 4'h0, 1, 0, 0, 0, 0);
      v(0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0);

      #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; start = vecs[i].start;
         sw = vecs[i].sw; ep = vecs[i].ep;
         exp_q.push_back(vecs[i]);
         tick();
         e = exp_q.pop_front();
         check("ap_idle", i, idle, e.idle);
         check("ap_done", i, done, e.done);
         check("ap_ready", i, ready, e.done);
         check("all_sync", i, sync, e.sync);
         check("all_waiting", i, aw, &e.sw);
         check("exec_count", i, exec, e.exec);
         check("round_count", i, round, e.round);
      end

      // saturation on the narrow instance
      s_rst = 1'b1; tick();
      check("sat_reset_idle", 0, s_idle, 1);
      s_rst = 1'b0; s_start = 1'b1; tick();
      s_start = 1'b0; s_sw = 4'h0; s_ep = 4'h1;
      repeat (20) tick();
      check("sat_exec", 1, s_exec, 15);
      s_ep = 4'h0; s_sw = 4'hF; tick();
      check("sat_sync", 2, s_sync, 1);
      for (int r = 0; r < 10; r++) begin
         s_ep = 4'h0;
         repeat (3) tick();
         s_ep = 4'h1;
         tick();
      end
      check("sat_round", 3, s_round, 7);
      check("sat_exec_hold", 4, s_exec, 15);
      s_ep = 4'h0;
      repeat (4) tick();
      check("sat_done", 5, s_done, 1);
      check("sat_round_final", 6, s_round, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
